// File: rtl/frv_mem_bus_arbiter.sv
// Two-port (fetch I / LSU D) arbiter onto one request/grant memory bus.
// Define FRV_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise fixed priority.
module frv_mem_bus_arbiter #(
  parameter bit FRV_ARB_D_PRIORITY = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        i_req,
  input  logic        i_wen,
  input  logic [3:0]  i_strb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_gnt,
  output logic        i_error,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [3:0]  d_strb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_error,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_error,
  input  logic [31:0] m_rdata
);
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  logic   locked_q, locked_d;
  owner_e lock_owner_q, lock_owner_d;
  logic   rsp_pending_q, rsp_pending_d;
  owner_e rsp_owner_q, rsp_owner_d;
  owner_e sel;
  logic   lock_req;
`ifdef FRV_ARB_ROUND_ROBIN_EN
  owner_e last_owner_q, last_owner_d;
`endif

  // A locked owner that dropped its req falls through to fresh arbitration.
  always_comb begin
    lock_req = (lock_owner_q == OWN_D) ? d_req : i_req;
    sel      = OWN_I;
    if (locked_q && lock_req) begin
      sel = lock_owner_q;
    end else if (i_req && d_req) begin
`ifdef FRV_ARB_ROUND_ROBIN_EN
      sel = (last_owner_q == OWN_I) ? OWN_D : OWN_I;
`else
      sel = FRV_ARB_D_PRIORITY ? OWN_D : OWN_I;
`endif
    end else if (d_req) begin
      sel = OWN_D;
    end
  end

  always_comb begin
    m_req   = g_resetn & ((sel == OWN_D) ? d_req : i_req);
    m_wen   = (sel == OWN_D) ? d_wen   : i_wen;
    m_strb  = (sel == OWN_D) ? d_strb  : i_strb;
    m_addr  = (sel == OWN_D) ? d_addr  : i_addr;
    m_wdata = (sel == OWN_D) ? d_wdata : i_wdata;
    i_gnt   = g_resetn & m_gnt & (sel == OWN_I);
    d_gnt   = g_resetn & m_gnt & (sel == OWN_D);
  end

  always_comb begin
    locked_d      = 1'b0;
    lock_owner_d  = lock_owner_q;
    rsp_pending_d = m_gnt;
    rsp_owner_d   = rsp_owner_q;
    if (!m_gnt && m_req) begin
      locked_d     = 1'b1;
      lock_owner_d = sel;
    end
    if (m_gnt) rsp_owner_d = sel;
  end

`ifdef FRV_ARB_ROUND_ROBIN_EN
  always_comb begin
    last_owner_d = last_owner_q;
    if (m_gnt) last_owner_d = sel;
  end
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      locked_q      <= 1'b0;
      lock_owner_q  <= OWN_I;
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= OWN_I;
`ifdef FRV_ARB_ROUND_ROBIN_EN
      last_owner_q  <= OWN_I;
`endif
    end else begin
      locked_q      <= locked_d;
      lock_owner_q  <= lock_owner_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
`ifdef FRV_ARB_ROUND_ROBIN_EN
      last_owner_q  <= last_owner_d;
`endif
    end
  end

  // Response returns the cycle after grant, only to the port that was granted.
  always_comb begin
    i_rdata = '0;
    i_error = 1'b0;
    d_rdata = '0;
    d_error = 1'b0;
    if (g_resetn && rsp_pending_q) begin
      if (rsp_owner_q == OWN_I) begin
        i_rdata = m_rdata;
        i_error = m_error;
      end else begin
        d_rdata = m_rdata;
        d_error = m_error;
      end
    end
  end
endmodule

// File: tb/tb_frv_mem_bus_arbiter.sv
// Directed scoreboard bench for frv_mem_bus_arbiter (default fixed-priority build, D wins).
module tb_frv_mem_bus_arbiter;
  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        i_req, i_wen, d_req, d_wen, m_gnt, m_error;
  logic [3:0]  i_strb, d_strb;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
  logic        i_gnt, i_error, d_gnt, d_error, m_req, m_wen;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_strb;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { bit pend; bit own_d; } exp_t;
  exp_t sbq[$];

  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] DA = 32'h2000_0040;

  always #5 g_clk = ~g_clk;

  frv_mem_bus_arbiter dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .i_req(i_req), .i_wen(i_wen), .i_strb(i_strb), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_error(i_error), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_strb(d_strb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_error(d_error), .d_rdata(d_rdata),
    .m_req(m_req), .m_wen(m_wen), .m_strb(m_strb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_error(m_error), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check 1ns later; exp_d = bench's expected owner.
  task automatic step(input string tag, input bit ireq, input bit dreq, input bit dwen,
                      input bit mgnt, input logic [31:0] mrd, input bit merr,
                      input bit exp_d);
    exp_t e;
    bit   exp_mreq;
    @(negedge g_clk);
    i_req = ireq; d_req = dreq; d_wen = dwen; d_strb = dwen ? 4'hF : 4'h0;
    m_gnt = mgnt; m_rdata = mrd; m_error = merr;
    #1;
    e = sbq.pop_front();
    exp_mreq = exp_d ? dreq : ireq;
    chk({tag, ".m_req"},  {31'd0, m_req},  {31'd0, exp_mreq});
    chk({tag, ".i_gnt"},  {31'd0, i_gnt},  {31'd0, mgnt && !exp_d});
    chk({tag, ".d_gnt"},  {31'd0, d_gnt},  {31'd0, mgnt && exp_d});
    chk({tag, ".m_addr"}, m_addr, exp_d ? DA : IA);
    chk({tag, ".m_wen"},  {31'd0, m_wen},  {31'd0, exp_d && dwen});
    chk({tag, ".i_rdata"}, i_rdata, (e.pend && !e.own_d) ? mrd : 32'd0);
    chk({tag, ".d_rdata"}, d_rdata, (e.pend &&  e.own_d) ? mrd : 32'd0);
    chk({tag, ".i_error"}, {31'd0, i_error}, {31'd0, e.pend && !e.own_d && merr});
    chk({tag, ".d_error"}, {31'd0, d_error}, {31'd0, e.pend &&  e.own_d && merr});
    sbq.push_back('{pend: mgnt, own_d: exp_d});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".m_req"},   {31'd0, m_req},   32'd0);
    chk({tag, ".i_gnt"},   {31'd0, i_gnt},   32'd0);
    chk({tag, ".d_gnt"},   {31'd0, d_gnt},   32'd0);
    chk({tag, ".i_rdata"}, i_rdata, 32'd0);
    chk({tag, ".d_rdata"}, d_rdata, 32'd0);
    chk({tag, ".i_error"}, {31'd0, i_error}, 32'd0);
    chk({tag, ".d_error"}, {31'd0, d_error}, 32'd0);
  endtask

  initial begin
    i_addr = IA; i_wdata = 32'h0; i_wen = 1'b0; i_strb = 4'h0;
    d_addr = DA; d_wdata = 32'h5A5A_0F0F; d_wen = 1'b0; d_strb = 4'h0;
    // Reset with everything requesting and bus granting: outputs must stay quiet.
    g_resetn = 1'b0; i_req = 1'b1; d_req = 1'b1; m_gnt = 1'b1;
    m_rdata = 32'hDEAD_BEEF; m_error = 1'b1;
    #1 chk_reset_outputs("rst");
    repeat (2) @(posedge g_clk);
    @(negedge g_clk) g_resetn = 1'b1; i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
    sbq.push_back('{pend: 1'b0, own_d: 1'b0});

    // Single fetch, response on the next cycle.
    step("i_single", 1, 0, 0, 1, 32'h0,        0, 0);
    step("i_rsp",    0, 0, 0, 0, 32'h0000_0013, 0, 0);
    // Contention: D wins twice, then I once D drops.
    step("cont0",    1, 1, 0, 1, 32'h0,        0, 1);
    step("cont1",    1, 1, 0, 1, 32'h0000_AAAA, 0, 1);
    step("cont_i",   1, 0, 0, 1, 32'h0000_BBBB, 0, 0);
    step("cont_rsp", 0, 0, 0, 0, 32'h0000_CCCC, 0, 0);
    // Lock on I while D arrives; D gets the bus only after I's grant.
    step("lock0",    1, 0, 0, 0, 32'h0,        0, 0);
    step("lock1",    1, 1, 0, 0, 32'h0,        0, 0);
    step("lock2",    1, 1, 0, 0, 32'h0,        0, 0);
    step("lock_g",   1, 1, 0, 1, 32'h0,        0, 0);
    step("lock_nxt", 1, 1, 0, 0, 32'h0000_1111, 0, 1);
    // D (locked owner) drops before grant: fresh arbitration gives I that cycle.
    step("drop",     1, 0, 0, 0, 32'h0,        0, 0);
    // I drops too; D store is granted, then errors for exactly one cycle.
    step("st_g",     0, 1, 1, 1, 32'h0,        0, 1);
    step("st_err",   0, 0, 0, 0, 32'h0,        1, 0);
    step("st_err2",  0, 0, 0, 0, 32'h0,        1, 0);
    // Back-to-back: response to D and new grant to I in the same cycle.
    step("b2b0",     0, 1, 0, 1, 32'h0,        0, 1);
    step("b2b1",     1, 0, 0, 1, 32'h0000_2222, 0, 0);
    step("b2b2",     0, 0, 0, 0, 32'h0000_3333, 0, 0);
    // Lock D, then reset mid-wait; the lock must not survive.
    step("pre_rst",  1, 1, 0, 0, 32'h0,        0, 1);
    @(negedge g_clk);
    g_resetn = 1'b0; m_gnt = 1'b1; m_rdata = 32'h7777_7777; m_error = 1'b1;
    #1 chk_reset_outputs("rst_mid");
    @(posedge g_clk);
    @(negedge g_clk) g_resetn = 1'b1; m_gnt = 1'b0; i_req = 1'b0; d_req = 1'b0;
    sbq.delete();
    sbq.push_back('{pend: 1'b0, own_d: 1'b0});
    step("post_rst", 1, 0, 0, 1, 32'h0,        0, 0);
    step("post_rsp", 0, 0, 0, 0, 32'h0000_4444, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
